// File: rtl/digit_sender.sv
// Sends a captured two-digit BCD value as a tens key and a ones key over a
// valid/ready handshake, with a programmable idle gap between the two keys.
module digit_sender #(
  parameter int unsigned GAP     = 4,
  parameter bit          SKIP_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ten_in,
  input  logic [3:0] one_in,
  input  logic       key_ready,
  output logic [3:0] key_out,
  output logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] BCD_MAX  = DW'(9);
  localparam logic [CW-1:0] GAP_LOAD = (GAP == 0) ? '0 : CW'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SEND_TEN,
    GAP_WAIT,
    SEND_ONE,
    FINISH
  } state_t;

  state_t        state;
  logic [CW-1:0] gap_cnt;
  logic [DW-1:0] ten_q;
  logic [DW-1:0] one_q;

  // Outputs are updated on the same edge as the state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      gap_cnt   <= '0;
      ten_q     <= '0;
      one_q     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ten_q <= ten_in;
            one_q <= one_in;
            state <= CHECK;
            busy  <= 1'b1;
            // err is visible during CHECK, so it is decided from the digits being captured
            err   <= (ten_in > BCD_MAX) || (one_in > BCD_MAX);
          end
        end

        CHECK: begin
          if ((ten_q > BCD_MAX) || (one_q > BCD_MAX)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (SKIP_LZ && (ten_q == '0)) begin
            state     <= SEND_ONE;
            key_valid <= 1'b1;
            key_out   <= one_q;
          end else begin
            state     <= SEND_TEN;
            key_valid <= 1'b1;
            key_out   <= ten_q;
          end
        end

        SEND_TEN: begin
          if (key_ready) begin
            if (GAP == 0) begin
              state   <= SEND_ONE;
              key_out <= one_q;
            end else begin
              state     <= GAP_WAIT;
              key_valid <= 1'b0;
              gap_cnt   <= GAP_LOAD;
            end
          end
        end

        GAP_WAIT: begin
          if (gap_cnt == '0) begin
            state     <= SEND_ONE;
            key_valid <= 1'b1;
            key_out   <= one_q;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end

        SEND_ONE: begin
          if (key_ready) begin
            state     <= FINISH;
            key_valid <= 1'b0;
            done      <= 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          key_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_sender.sv
// Self-checking bench: two instances (GAP=4/skip leading zero, GAP=0/no skip)
// share stimulus; each is checked against a transaction-level expectation.
module tb_digit_sender;

  localparam int unsigned GAP_A = 4;
  localparam int unsigned GAP_B = 0;
  localparam int          BUDGET = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       key_ready;
  logic [3:0] ten_in;
  logic [3:0] one_in;

  logic [3:0] key_out_a, key_out_b;
  logic       key_valid_a, key_valid_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

  logic [3:0] ko [2];
  logic       kv [2];
  logic       bz [2];
  logic       dn [2];
  logic       er [2];

  assign ko[0] = key_out_a;   assign ko[1] = key_out_b;
  assign kv[0] = key_valid_a; assign kv[1] = key_valid_b;
  assign bz[0] = busy_a;      assign bz[1] = busy_b;
  assign dn[0] = done_a;      assign dn[1] = done_b;
  assign er[0] = err_a;       assign er[1] = err_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_sender #(.GAP(GAP_A), .SKIP_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .ten_in(ten_in), .one_in(one_in),
    .key_ready(key_ready), .key_out(key_out_a), .key_valid(key_valid_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  digit_sender #(.GAP(GAP_B), .SKIP_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .ten_in(ten_in), .one_in(one_in),
    .key_ready(key_ready), .key_out(key_out_b), .key_valid(key_valid_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  function automatic int gap_of(input int d);
    return (d == 0) ? int'(GAP_A) : int'(GAP_B);
  endfunction

  function automatic bit skip_of(input int d);
    return (d == 0);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; ten_in = 4'd0; one_in = 4'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++; if (ko[d] !== 4'd0) begin bad++; $display("FAIL reset_key_out dut%0d got %0d want 0", d, ko[d]); end
      total++; if (kv[d] !== 1'b0) begin bad++; $display("FAIL reset_key_valid dut%0d got %b want 0", d, kv[d]); end
      total++; if (bz[d] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got %b want 0", d, bz[d]); end
      total++; if (dn[d] !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d got %b want 0", d, dn[d]); end
      total++; if (er[d] !== 1'b0) begin bad++; $display("FAIL reset_err dut%0d got %b want 0", d, er[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low until cycle 7
  task automatic run_txn(input logic [3:0] t, input logic [3:0] o, input int mode, input string name);
    bit         bad_in;
    bit         finished;
    int         c;
    int         n_exp;
    logic [3:0] e [2];
    int         ndig [2], noff [2], ndone [2], nerr [2];
    int         done_cyc [2], err_cyc [2], fall_cyc [2];
    logic [3:0] dig [2][4];
    int         xcyc [2][4];
    int         ocyc [2][4];
    logic       pv [2], px [2];
    logic [3:0] po [2];
    logic       pr;

    bad_in = (t > 4'd9) || (o > 4'd9);
    for (int d = 0; d < 2; d++) begin
      ndig[d] = 0; noff[d] = 0; ndone[d] = 0; nerr[d] = 0;
      done_cyc[d] = -1; err_cyc[d] = -1; fall_cyc[d] = -1;
      pv[d] = kv[d]; px[d] = 1'b0; po[d] = ko[d];
      for (int i = 0; i < 4; i++) begin dig[d][i] = 4'd0; xcyc[d][i] = -1; ocyc[d][i] = -1; end
    end

    c = 0;
    start = 1'b1; ten_in = t; one_in = o;
    key_ready = (mode == 2) ? 1'b0 : 1'b1;
    pr = key_ready;
    finished = 1'b0;

    while (!finished && c < BUDGET) begin
      @(negedge clk);
      c++;
      start  = 1'b0;
      ten_in = 4'($urandom);
      one_in = 4'($urandom);
      for (int d = 0; d < 2; d++) begin
        if (pv[d] && !pr) begin
          total++;
          if (kv[d] !== 1'b1 || ko[d] !== po[d]) begin
            bad++;
            $display("FAIL %s hold dut%0d cyc%0d got valid=%b key=%0d want valid=1 key=%0d", name, d, c, kv[d], ko[d], po[d]);
          end
        end
        if (kv[d] && (!pv[d] || px[d])) begin
          if (noff[d] < 4) ocyc[d][noff[d]] = c;
          noff[d]++;
        end
        if (dn[d]) begin ndone[d]++; done_cyc[d] = c; end
        if (er[d]) begin nerr[d]++; err_cyc[d] = c; end
        if (!bz[d] && fall_cyc[d] < 0) fall_cyc[d] = c;
      end

      case (mode)
        0:       key_ready = 1'b1;
        2:       key_ready = (c >= 7);
        default: key_ready = ($urandom_range(3, 0) != 0);
      endcase

      for (int d = 0; d < 2; d++) begin
        px[d] = kv[d] && key_ready;
        if (px[d]) begin
          if (ndig[d] < 4) begin dig[d][ndig[d]] = ko[d]; xcyc[d][ndig[d]] = c; end
          ndig[d]++;
        end
        pv[d] = kv[d];
        po[d] = ko[d];
      end
      pr = key_ready;

      // Extra starts while both instances are busy (incl. FINISH) must be ignored
      if (bz[0] && bz[1] && (($urandom_range(1, 0) == 1) || dn[0] || dn[1])) start = 1'b1;
      finished = (fall_cyc[0] >= 0) && (fall_cyc[1] >= 0);
    end
    start = 1'b0;

    total++;
    if (!finished) begin
      bad++;
      $display("FAIL %s timeout after %0d cycles want idle", name, c);
    end

    for (int d = 0; d < 2; d++) begin
      if (bad_in) n_exp = 0;
      else if (skip_of(d) && t == 4'd0) n_exp = 1;
      else n_exp = 2;
      e[0] = (n_exp == 1) ? o : t;
      e[1] = o;

      total++; if (ndig[d] !== n_exp) begin bad++; $display("FAIL %s xfer_count dut%0d got %0d want %0d", name, d, ndig[d], n_exp); end
      total++; if (noff[d] !== n_exp) begin bad++; $display("FAIL %s offer_count dut%0d got %0d want %0d", name, d, noff[d], n_exp); end
      for (int i = 0; i < n_exp && i < ndig[d]; i++) begin
        total++; if (dig[d][i] !== e[i]) begin bad++; $display("FAIL %s digit%0d dut%0d got %0d want %0d", name, i, d, dig[d][i], e[i]); end
      end
      total++; if (ndone[d] !== (bad_in ? 0 : 1)) begin bad++; $display("FAIL %s done_count dut%0d got %0d want %0d", name, d, ndone[d], bad_in ? 0 : 1); end
      total++; if (nerr[d] !== (bad_in ? 1 : 0)) begin bad++; $display("FAIL %s err_count dut%0d got %0d want %0d", name, d, nerr[d], bad_in ? 1 : 0); end

      if (bad_in) begin
        total++; if (err_cyc[d] !== 1) begin bad++; $display("FAIL %s err_cycle dut%0d got %0d want 1", name, d, err_cyc[d]); end
        total++; if (fall_cyc[d] !== 2) begin bad++; $display("FAIL %s idle_cycle dut%0d got %0d want 2", name, d, fall_cyc[d]); end
      end else begin
        total++; if (ocyc[d][0] !== 2) begin bad++; $display("FAIL %s first_offer dut%0d got %0d want 2", name, d, ocyc[d][0]); end
        total++; if (fall_cyc[d] !== done_cyc[d] + 1) begin bad++; $display("FAIL %s idle_cycle dut%0d got %0d want %0d", name, d, fall_cyc[d], done_cyc[d] + 1); end
        if (ndig[d] >= n_exp) begin
          total++; if (done_cyc[d] !== xcyc[d][n_exp-1] + 1) begin bad++; $display("FAIL %s done_cycle dut%0d got %0d want %0d", name, d, done_cyc[d], xcyc[d][n_exp-1] + 1); end
        end
        if (n_exp == 2 && noff[d] >= 2) begin
          total++; if (ocyc[d][1] !== xcyc[d][0] + 1 + gap_of(d)) begin bad++; $display("FAIL %s gap dut%0d ones at %0d want %0d", name, d, ocyc[d][1], xcyc[d][0] + 1 + gap_of(d)); end
        end
        if (mode == 0) begin
          total++; if (done_cyc[d] !== ((n_exp == 2) ? 4 + gap_of(d) : 3)) begin bad++; $display("FAIL %s latency dut%0d done at %0d want %0d", name, d, done_cyc[d], (n_exp == 2) ? 4 + gap_of(d) : 3); end
        end
        if (mode == 2) begin
          total++; if (xcyc[d][0] !== 7) begin bad++; $display("FAIL %s stall_xfer dut%0d got %0d want 7", name, d, xcyc[d][0]); end
        end
      end
    end
  endtask

  task automatic test_quiet(input int cycles, input string name);
    int hits [2];
    hits[0] = 0; hits[1] = 0;
    repeat (cycles) begin
      key_ready = 1'($urandom);
      ten_in = 4'($urandom);
      one_in = 4'($urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (kv[d] || bz[d] || dn[d] || er[d]) hits[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      total++; if (hits[d] !== 0) begin bad++; $display("FAIL %s activity dut%0d got %0d cycles want 0", name, d, hits[d]); end
    end
  endtask

  task automatic test_reset_midgap();
    start = 1'b1; ten_in = 4'd4; one_in = 4'd2; key_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (kv[0] !== 1'b0 || bz[0] !== 1'b1) begin bad++; $display("FAIL midgap_state dut0 got valid=%b busy=%b want valid=0 busy=1", kv[0], bz[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ko[d] !== 4'd0 || kv[d] !== 1'b0 || bz[d] !== 1'b0 || dn[d] !== 1'b0 || er[d] !== 1'b0) begin
        bad++;
        $display("FAIL midgap_reset dut%0d got key=%0d valid=%b busy=%b done=%b err=%b want all 0", d, ko[d], kv[d], bz[d], dn[d], er[d]);
      end
    end
    test_quiet(8, "after_midgap_reset");
    run_txn(4'd6, 4'd1, 0, "fresh_after_reset");
  endtask

  task automatic test_reset_with_start();
    rst = 1'b1; start = 1'b1; ten_in = 4'd5; one_in = 4'd6;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    test_quiet(6, "reset_wins_start");
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      run_txn(4'($urandom_range(11, 0)), 4'($urandom_range(10, 0)), 1, "random");
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    run_txn(4'd4, 4'd2, 0, "basic_42");
    run_txn(4'd0, 4'd7, 0, "leading_zero");
    run_txn(4'd3, 4'd8, 2, "backpressure");
    run_txn(4'hA, 4'd3, 0, "bad_tens");
    run_txn(4'd2, 4'hF, 0, "bad_ones");
    run_txn(4'd9, 4'd9, 0, "back_to_back_1");
    run_txn(4'd1, 4'd0, 0, "back_to_back_2");
    test_reset_midgap();
    test_reset_with_start();
    test_random(25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
